cpu_multicycle: RTL
===================

Name: cpu_multicycle

Overview:
- Parametrised multi-cycle successor to the single-cycle CPU core.
- Fetches 32-bit instructions over a req/ack instruction-memory handshake.
- Executes an FSM of FETCH → DECODE → EXEC → WB, with an internal register file of NREGS×XLEN, sign-extended immediates, conditional branch and HALT.
- Sits between the instruction memory (imem) and the debug/test harness.

Parameters:
- XLEN, 32, datapath/register width (8..64).
- NREGS, 8, register count, power of two, 2..32; RW = $clog2(NREGS).
- PC_WIDTH, 8, instruction address width; PC wraps modulo 2^PC_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  PC_WIDTH  word address = pc, stable while imem_req
- imem_ack  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- retire  out  1  one-cycle pulse in WB
- halted  out  1  core in HALT state
- debug_inst  out  32  current instruction register (IR)
- debug_data  out  XLEN  last value written to the register file

Behaviour:
- Encoding:
  - op [31:28]; imm flag [27]; rd [26:22]; rs1 [21:17]; rs2 [16:12]; imm12 [11:0].
  - imm12 is sign-extended to XLEN.
  - Register indices use only the low RW bits of each field.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 1/0).
  - 6 BEQ, 7 JMP, 15 HALT.
  - All others are NOP (no writeback, pc+1).
  - ALU operand B = imm flag ? sext(imm12) : regs[rs2].
  - Arithmetic is modulo 2^XLEN.
- r0 is hardwired zero: reads return 0, writes are discarded. debug_data still updates on a discarded write.
- Reset (any state, including mid-fetch):
  - State→FETCH, pc=0, IR=0, all regs=0.
  - imem_req=0, retire=0, halted=0, debug_data=0.
  - imem_req asserts in the first cycle after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: IR←imem_rdata, go to DECODE.
  - imem_req drops in the cycle after ack.
  - imem_ack while imem_req=0 is ignored.
- DECODE: A←reg[rs1], B←operand B (registered).
- EXEC:
  - R←ALU(op,A,B).
  - Branch-taken flag: BEQ: A==reg[rs2] (imm flag ignored); JMP: always.
- WB:
  - For ALU ops, write R to rd and set debug_data←R.
  - pc←taken ? pc+sext(imm12) : pc+1, truncated to PC_WIDTH (wraps).
  - retire=1 for one cycle.
  - Next state FETCH, or HALT for op 15.
- HALT:
  - halted=1; no further requests.
  - Exits only via reset; pc remains at the HALT address.
- Latency: 4 cycles per instruction with zero-wait ack; each ack wait cycle adds 1.
- No write-back bypass is needed: register writes complete before the next DECODE.

Optional Feature:
- Macro CPU_MUL_EN.
- Defined: opcode 8 = MUL, with R = low XLEN bits of A×B (unsigned), completing in the single EXEC cycle.
- Undefined: opcode 8 is a NOP; no multiplier is synthesised.

Decomposition:
- Package cpu_pkg:
  - opcode localparams;
  - FSM state enum (FETCH, DECODE, EXEC, WB, HALT);
  - field bit positions;
  - sext helper function.
- Sub-module cpu_alu: combinational, parametrised by XLEN; contains the op decode and the `ifdef CPU_MUL_EN` multiply path.
- The register file stays inline.

Test Plan:
- Reset, then ack always 1; program: ADD r1,r0,#5; ADD r2,r1,#-3 → r2=2, debug_data=2, retire pulses 4 cycles apart.
- Ack delayed 3 cycles on each fetch → imem_addr/imem_req held stable; each instruction takes 7 cycles; results are identical.
- r1=7, r2=7, BEQ r1,r2,#-2 at pc=10 → next fetch address 8; with r2=6 → 11.
- PC_WIDTH=8, JMP #+1 at pc=255 → next fetch address 0.
- ADD r0,r0,#9 then ADD r3,r0,r0 → r3=0. HALT at pc=4 → halted=1 and no imem_req; reset asserted mid-FETCH → pc=0 and regs cleared.
- With CPU_MUL_EN, MUL r4,r1,#-1 with r1=3 (XLEN=32) → r4=0xFFFFFFFD; without the macro → r4 is unchanged and pc+1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU core: opcodes, instruction
// field positions, FSM state encoding and the immediate sign-extension helper.
package cpu_pkg;

    // Opcodes (instruction bits [31:28]); anything not listed is a NOP.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Instruction field positions.
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 28;
    localparam int IMMF_BIT = 27;
    localparam int RD_LO    = 22;
    localparam int RS1_LO   = 17;
    localparam int RS2_LO   = 12;
    localparam int IMM_HI   = 11;
    localparam int IMM_LO   = 0;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // Sign-extend imm12 to 64 bits; callers cast down to the width they need.
    function automatic logic [63:0] sext12(input logic [11:0] imm);
        return {{52{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multi-cycle core. Decodes the opcode, produces
// the result and flags whether the opcode writes the register file.
// Macro CPU_MUL_EN: when defined, opcode 8 is an unsigned MUL keeping the low
// XLEN bits; when undefined opcode 8 falls into the NOP group.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            writes_o
);

    // Opcode decode and result select; non-ALU opcodes produce no writeback.
    always_comb begin
        result_o = '0;
        writes_o = 1'b1;
        case (op_i)
            OP_ADD: result_o = a_i + b_i;
            OP_SUB: result_o = a_i - b_i;
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SLT: result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
`ifdef CPU_MUL_EN
            OP_MUL: result_o = a_i * b_i;
`endif
            default: writes_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle CPU core: FETCH -> DECODE -> EXEC -> WB, with a req/ack
// instruction fetch, an inline NREGS x XLEN register file (r0 reads as zero),
// conditional branch, jump and HALT.
// Macro CPU_MUL_EN (in cpu_alu): enables opcode 8 as MUL.
//
// Fetch handshake: imem_req is held high with imem_addr = pc stable until a
// cycle in which imem_ack is high; that cycle transfers imem_rdata into IR and
// imem_req drops on the next cycle. imem_ack while imem_req is low is ignored.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 8,
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic                retire,
    output logic                halted,
    output logic [31:0]         debug_inst,
    output logic [XLEN-1:0]     debug_data
);

    localparam int RW = $clog2(NREGS);

    state_e                state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [31:0]           ir_q;
    logic [XLEN-1:0]       a_q;
    logic [XLEN-1:0]       b_q;
    logic [XLEN-1:0]       cmp_q;
    logic [XLEN-1:0]       r_q;
    logic                  taken_q;
    logic                  req_q;
    logic                  retire_q;
    logic                  halted_q;
    logic [XLEN-1:0]       dbg_q;
    logic [XLEN-1:0]       rf_q [NREGS];

    // Decoded fields of the held instruction.
    logic [3:0]            op;
    logic                  immf;
    logic [RW-1:0]         rd;
    logic [RW-1:0]         rs1;
    logic [RW-1:0]         rs2;
    logic [XLEN-1:0]       imm_x;
    logic [PC_WIDTH-1:0]   imm_pc;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [XLEN-1:0]       b_d;
    logic [PC_WIDTH-1:0]   pc_d;
    logic                  taken_d;
    logic [XLEN-1:0]       alu_res;
    logic                  alu_wr;

    assign op      = ir_q[OP_HI:OP_LO];
    assign immf    = ir_q[IMMF_BIT];
    assign rd      = ir_q[RD_LO +: RW];
    assign rs1     = ir_q[RS1_LO +: RW];
    assign rs2     = ir_q[RS2_LO +: RW];
    assign imm_x   = XLEN'(sext12(ir_q[IMM_HI:IMM_LO]));
    assign imm_pc  = PC_WIDTH'(sext12(ir_q[IMM_HI:IMM_LO]));
    assign rs1_val = (rs1 == '0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == '0) ? '0 : rf_q[rs2];
    assign b_d     = immf ? imm_x : rs2_val;
    // BEQ compares against the register even when the imm flag is set.
    assign taken_d = (op == OP_BEQ) ? (a_q == cmp_q) : (op == OP_JMP);
    // PC wraps naturally through truncation to PC_WIDTH.
    assign pc_d    = taken_q ? (pc_q + imm_pc) : (pc_q + PC_WIDTH'(1));

    cpu_alu #(.XLEN(XLEN)) u_alu (
        .op_i     (op),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_res),
        .writes_o (alu_wr)
    );

    // Control FSM, datapath registers and register file; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cmp_q    <= '0;
            r_q      <= '0;
            taken_q  <= 1'b0;
            req_q    <= 1'b0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            dbg_q    <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    // First cycle out of reset raises the request; afterwards
                    // WB raises it on the way back into FETCH.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        req_q   <= 1'b0;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a_q     <= rs1_val;
                    b_q     <= b_d;
                    cmp_q   <= rs2_val;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_q      <= alu_res;
                    taken_q  <= taken_d;
                    retire_q <= 1'b1;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    if (alu_wr) begin
                        if (rd != '0) begin
                            rf_q[rd] <= r_q;
                        end
                        dbg_q <= r_q;
                    end
                    if (op == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        pc_q    <= pc_d;
                        req_q   <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign retire     = retire_q;
    assign halted     = halted_q;
    assign debug_inst = ir_q;
    assign debug_data = dbg_q;

endmodule
